// File: rtl/quad_decoder.sv
// Quadrature encoder decoder: 2-flop synchronizers, run-length glitch filter,
// Gray-state decoder with step/direction pulses, loadable position counter and sticky error.
module quad_decoder #(
  parameter int Nbits = 8,
  parameter int FILT  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             quad_a,
  input  logic             quad_b,
  input  logic             Load,
  input  logic [Nbits-1:0] Data,
  input  logic             clr_err,
  output logic             step,
  output logic             UpDwn,
  output logic [Nbits-1:0] position,
  output logic             err
);

  typedef enum logic [1:0] {
    S00 = 2'b00,
    S01 = 2'b01,
    S11 = 2'b11,
    S10 = 2'b10
  } state_e;

  localparam logic [3:0]       FILT_C   = 4'(FILT);
  localparam logic [4:0]       SETTLE_C = 5'(FILT + 3);
  localparam logic [Nbits-1:0] ONE_C    = {{(Nbits-1){1'b0}}, 1'b1};

  function automatic logic [1:0] fwd_of(input logic [1:0] s);
    case (s)
      2'b00:   fwd_of = 2'b01;
      2'b01:   fwd_of = 2'b11;
      2'b11:   fwd_of = 2'b10;
      2'b10:   fwd_of = 2'b00;
      default: fwd_of = 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] bwd_of(input logic [1:0] s);
    case (s)
      2'b00:   bwd_of = 2'b10;
      2'b10:   bwd_of = 2'b11;
      2'b11:   bwd_of = 2'b01;
      2'b01:   bwd_of = 2'b00;
      default: bwd_of = 2'b00;
    endcase
  endfunction

  logic [1:0]       sync1_q, sync1_d, sync2_q, sync2_d;
  logic [1:0]       filt_q, filt_d, cand_q, cand_d;
  logic [3:0]       cnt_q, cnt_d, run_len_s;
  logic [4:0]       settle_q, settle_d;
  state_e           state_q, state_d;
  logic             step_q, step_d, updwn_q, updwn_d, err_q, err_d;
  logic [Nbits-1:0] pos_q, pos_d;
  logic             mv_up_s, mv_dn_s, mv_bad_s;

  // Synchronizer shift and glitch filter: commit a new {A,B} after FILT identical differing samples.
  always_comb begin
    sync1_d   = {quad_a, quad_b};
    sync2_d   = sync1_q;
    filt_d    = filt_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    run_len_s = 4'd1;
    if (sync2_q == filt_q) begin
      cnt_d = 4'd0;
    end else begin
      if ((cnt_q == 4'd0) || (sync2_q != cand_q)) begin
        run_len_s = 4'd1;
      end else begin
        run_len_s = cnt_q + 4'd1;
      end
      cand_d = sync2_q;
      if (run_len_s >= FILT_C) begin
        filt_d = sync2_q;
        cnt_d  = 4'd0;
      end else begin
        cnt_d = run_len_s;
      end
    end
  end

  assign mv_up_s  = (filt_q == fwd_of(state_q));
  assign mv_dn_s  = (filt_q == bwd_of(state_q));
  assign mv_bad_s = (filt_q == ~state_q);

  // Decoder: state always follows the filter; outputs act only outside the post-reset settle window.
  always_comb begin
    state_d  = state_e'(filt_q);
    settle_d = settle_q;
    step_d   = 1'b0;
    updwn_d  = updwn_q;
    pos_d    = pos_q;
    err_d    = err_q;
    if (settle_q != 5'd0) begin
      settle_d = settle_q - 5'd1;
    end else if (ena) begin
      if (mv_up_s) begin
        step_d  = 1'b1;
        updwn_d = 1'b1;
        pos_d   = pos_q + ONE_C;
      end else if (mv_dn_s) begin
        step_d  = 1'b1;
        updwn_d = 1'b0;
        pos_d   = pos_q - ONE_C;
      end else begin
        step_d = 1'b0;
      end
      // Set has priority over clear.
      if (mv_bad_s) begin
        err_d = 1'b1;
      end else if (clr_err) begin
        err_d = 1'b0;
      end else begin
        err_d = err_q;
      end
    end else begin
      step_d = 1'b0;
    end
    if (Load) begin
      pos_d = Data;
    end else begin
      pos_d = pos_d;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 2'b00;
      sync2_q  <= 2'b00;
      filt_q   <= 2'b00;
      cand_q   <= 2'b00;
      cnt_q    <= 4'd0;
      settle_q <= SETTLE_C;
      state_q  <= S00;
      step_q   <= 1'b0;
      updwn_q  <= 1'b0;
      pos_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      filt_q   <= filt_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      settle_q <= settle_d;
      state_q  <= state_d;
      step_q   <= step_d;
      updwn_q  <= updwn_d;
      pos_q    <= pos_d;
      err_q    <= err_d;
    end
  end

  assign step     = step_q;
  assign UpDwn    = updwn_q;
  assign position = pos_q;
  assign err      = err_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Randomized bench for quad_decoder: encoder moves are tracked as a phase index (0..3)
// and expected outputs are scheduled FILT+3 edges after each accepted input change.
module tb_quad_decoder;
  localparam int Nbits = 8;
  localparam int FILT  = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             ena = 1'b1;
  logic             quad_a = 1'b0;
  logic             quad_b = 1'b0;
  logic             Load = 1'b0;
  logic [Nbits-1:0] Data = 8'h00;
  logic             clr_err = 1'b0;
  logic             step, UpDwn, err;
  logic [Nbits-1:0] position;

  quad_decoder #(.Nbits(Nbits), .FILT(FILT)) dut (
    .clk(clk), .rst(rst), .ena(ena), .quad_a(quad_a), .quad_b(quad_b),
    .Load(Load), .Data(Data), .clr_err(clr_err),
    .step(step), .UpDwn(UpDwn), .position(position), .err(err)
  );

  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         ev [64];
  logic [1:0] acc = 2'b00;
  logic [1:0] gray_tab [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  logic             m_step = 1'b0;
  logic             m_up = 1'b0;
  logic             m_err = 1'b0;
  logic [Nbits-1:0] m_pos = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int idx(input logic [1:0] v);
    case (v)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  // One clock: apply scheduled events using the controls seen by this edge, then compare.
  task automatic tick();
    logic r_s, e_s, l_s, c_s;
    logic [Nbits-1:0] d_s;
    int k;
    @(posedge clk);
    r_s = rst; e_s = ena; l_s = Load; c_s = clr_err; d_s = Data;
    cyc++;
    k = ev[cyc % 64];
    ev[cyc % 64] = 0;
    m_step = 1'b0;
    if (r_s) begin
      m_pos = 8'h00; m_up = 1'b0; m_err = 1'b0;
      for (int i = 0; i < 64; i++) ev[i] = 0;
    end else begin
      if (e_s) begin
        if (k == 1) begin m_step = 1'b1; m_up = 1'b1; m_pos = m_pos + 8'd1; end
        else if (k == 3) begin m_step = 1'b1; m_up = 1'b0; m_pos = m_pos - 8'd1; end
        if (k == 2) m_err = 1'b1;
        else if (c_s) m_err = 1'b0;
      end
      if (l_s) m_pos = d_s;
    end
    @(negedge clk);
    check("step", {31'd0, step}, {31'd0, m_step});
    check("UpDwn", {31'd0, UpDwn}, {31'd0, m_up});
    check("position", {24'd0, position}, {24'd0, m_pos});
    check("err", {31'd0, err}, {31'd0, m_err});
  endtask

  task automatic drive(input logic [1:0] v, input int hold, input bit pulse);
    int d;
    {quad_a, quad_b} = v;
    if (hold >= FILT && v != acc) begin
      d = (idx(v) - idx(acc)) & 3;
      ev[(cyc + FILT + 3) % 64] = d;
      acc = v;
    end
    for (int i = 0; i < hold; i++) begin
      tick();
      if (pulse) begin Load = 1'b0; clr_err = 1'b0; end
    end
  endtask

  task automatic do_reset(input logic [1:0] v);
    rst = 1'b1; {quad_a, quad_b} = v; Load = 1'b0; clr_err = 1'b0; ena = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    acc = v;
    repeat (FILT + 5) tick();
  endtask

  initial begin
    logic [1:0] nv;
    int r;
    for (int i = 0; i < 64; i++) ev[i] = 0;
    // Resting at 11 through reset: absorbed silently, next move 11->10 is an up step.
    do_reset(2'b11);
    drive(2'b10, 10, 1'b1);
    // Full up cycle from position 0.
    do_reset(2'b00);
    drive(2'b01, 10, 1'b1); drive(2'b11, 10, 1'b1);
    drive(2'b10, 10, 1'b1); drive(2'b00, 10, 1'b1);
    // Down wrap to 255, then load FF and wrap up to 0.
    do_reset(2'b00);
    drive(2'b10, 10, 1'b1);
    Load = 1'b1; Data = 8'hFF;
    drive(2'b10, 1, 1'b1);
    drive(2'b00, 10, 1'b1);
    // Short glitch ignored; two-cycle pulse accepted both ways.
    drive(2'b01, 1, 1'b1); drive(2'b00, 8, 1'b1);
    drive(2'b01, 2, 1'b1); drive(2'b00, 8, 1'b1);
    // Illegal jumps, clear colliding with a second illegal jump, then clear alone.
    drive(2'b11, 8, 1'b1);
    clr_err = 1'b1;
    drive(2'b00, 8, 1'b0);
    clr_err = 1'b0;
    drive(2'b11, 8, 1'b1);
    clr_err = 1'b1;
    drive(2'b11, 3, 1'b1);
    // Disabled rotation, then re-enable and one counted edge.
    ena = 1'b0;
    drive(2'b10, 6, 1'b1); drive(2'b00, 6, 1'b1); drive(2'b01, 6, 1'b1);
    ena = 1'b1;
    drive(2'b01, 4, 1'b1);
    drive(2'b11, 8, 1'b1);
    // Reset in the middle of a filter run.
    drive(2'b10, 2, 1'b1);
    do_reset(2'b10);
    drive(2'b00, 8, 1'b1);
    // Random moves, glitches, illegal jumps and control pulses.
    for (int n = 0; n < 300; n++) begin
      ena     = ($urandom_range(0, 9) != 0);
      Load    = ($urandom_range(0, 15) == 0);
      Data    = 8'($urandom);
      clr_err = ($urandom_range(0, 7) == 0);
      r = $urandom_range(0, 39);
      if (r == 0) begin
        do_reset(gray_tab[$urandom_range(0, 3)]);
      end else if (r < 5) begin
        drive(gray_tab[(idx(acc) + 2) & 3], $urandom_range(2, 8), 1'b1);
      end else if (r < 9) begin
        nv = acc;
        drive(gray_tab[(idx(acc) + 1) & 3], 1, 1'b1);
        drive(nv, 3, 1'b1);
      end else begin
        drive(gray_tab[(idx(acc) + (($urandom_range(0, 1) == 1) ? 1 : 3)) & 3],
              $urandom_range(2, 8), 1'b1);
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
